// File: rtl/prog_mem_loader_if.sv
// Byte-stream and program-memory write/read port bundle for prog_mem_loader.
// The master modport is the loader side; the slave modport is the bridge/memory side.
interface prog_mem_loader_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
);
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_addr;
   logic [DATA_W-1:0] pm_din;
   logic [DATA_W-1:0] pm_dout;

   modport master (
      input  s_data, s_valid, pm_dout,
      output s_ready, pm_we, pm_addr, pm_din
   );

   modport slave (
      output s_data, s_valid, pm_dout,
      input  s_ready, pm_we, pm_addr, pm_din
   );
endinterface

// File: rtl/prog_mem_loader.sv
// Streams a length-prefixed, checksummed program image into program memory while holding the core in reset.
// Optional read-back verify of every written word is enabled with `define PROG_MEM_LOADER_VERIFY_EN.
module prog_mem_loader #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 16,
   parameter int MAX_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   prog_mem_loader_if.master bus,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic [2:0]        err,
   output logic [ADDR_W:0]   words
);

   localparam int          CW    = ADDR_W + 1;
   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   typedef enum logic [3:0] {
      IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE,
`ifdef PROG_MEM_LOADER_VERIFY_EN
      VRFY_A, VRFY_C,
`endif
      CHK, FIN
   } state_t;

   state_t          state, next_state;
   logic [7:0]      sum;
   logic [7:0]      n_lo;
   logic [7:0]      lo_byte;
   logic [CW-1:0]   n;
   logic [15:0]     hdr;
   logic            xfer;
   logic            err_load;
   logic [2:0]      err_code;

   assign hdr  = {bus.s_data, n_lo};
   assign xfer = bus.s_valid & bus.s_ready;

`ifndef PROG_MEM_LOADER_VERIFY_EN
   logic [CW-1:0] words_inc;
   logic          unused_dout;
   assign words_inc   = words + 1'b1;
   assign unused_dout = ^bus.pm_dout;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Abort overrides every in-frame transition; the error code rides along with the FIN entry.
   always_comb begin
      next_state = state;
      err_load   = 1'b0;
      err_code   = 3'd0;
      unique case (state)
         IDLE:   if (start) next_state = HDR_LO;
         HDR_LO: if (xfer) next_state = HDR_HI;
         HDR_HI: begin
            if (xfer) begin
               if ({1'b0, hdr} > MAX_N) begin
                  next_state = FIN;
                  err_load   = 1'b1;
                  err_code   = 3'd2;
               end else if (hdr == 16'd0) begin
                  next_state = CHK;
               end else begin
                  next_state = DAT_LO;
               end
            end
         end
         DAT_LO: if (xfer) next_state = DAT_HI;
         DAT_HI: if (xfer) next_state = WRITE;
         WRITE: begin
`ifdef PROG_MEM_LOADER_VERIFY_EN
            next_state = VRFY_A;
`else
            next_state = (words_inc == n) ? CHK : DAT_LO;
`endif
         end
`ifdef PROG_MEM_LOADER_VERIFY_EN
         VRFY_A: next_state = VRFY_C;
         VRFY_C: begin
            if (bus.pm_dout != bus.pm_din) begin
               next_state = FIN;
               err_load   = 1'b1;
               err_code   = 3'd3;
            end else begin
               next_state = (words == n) ? CHK : DAT_LO;
            end
         end
`endif
         CHK: begin
            if (xfer) begin
               next_state = FIN;
               if (bus.s_data != sum) begin
                  err_load = 1'b1;
                  err_code = 3'd1;
               end
            end
         end
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (abort && state != IDLE && state != FIN) begin
         next_state = FIN;
         err_load   = 1'b1;
         err_code   = 3'd4;
      end
   end

   // s_ready drops on an abort cycle so no byte is consumed by a frame that is being cancelled.
   always_comb begin
      bus.s_ready = 1'b0;
      busy        = (state != IDLE);
      core_hold   = (state != IDLE);
      done        = (state == FIN);
      if (!abort) begin
         bus.s_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DAT_LO) ||
                       (state == DAT_HI) || (state == CHK);
      end
   end

   // pm_addr/pm_din are loaded only on the DAT_HI->WRITE edge, so they hold the last written word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.pm_we   <= 1'b0;
         bus.pm_addr <= '0;
         bus.pm_din  <= '0;
         sum         <= 8'd0;
         n_lo        <= 8'd0;
         n           <= '0;
         lo_byte     <= 8'd0;
         words       <= '0;
         err         <= 3'd0;
      end else begin
         bus.pm_we <= (next_state == WRITE);
         if (state == IDLE && start) begin
            err   <= 3'd0;
            words <= '0;
            sum   <= 8'd0;
         end
         if (xfer && state != CHK) sum <= sum + bus.s_data;
         if (xfer && state == HDR_LO) n_lo <= bus.s_data;
         if (xfer && state == HDR_HI) n <= CW'(hdr);
         if (xfer && state == DAT_LO) lo_byte <= bus.s_data;
         if (xfer && state == DAT_HI && next_state == WRITE) begin
            bus.pm_din  <= DATA_W'({bus.s_data, lo_byte});
            bus.pm_addr <= words[ADDR_W-1:0];
         end
         if (state == WRITE) words <= words + 1'b1;
         if (err_load) err <= err_code;
      end
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: good frame, checksum/length/abort errors, empty frame, reset mid-load.
// The read-back verify scenario is built only when PROG_MEM_LOADER_VERIFY_EN is defined.
module tb_prog_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic [2:0]  err;
   logic [14:0] words;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int wr_base;
   logic        stuck_bit0 = 1'b0;
   logic [15:0] mem [16];

   prog_mem_loader_if #(.ADDR_W(14), .DATA_W(16)) bus ();

   prog_mem_loader #(.ADDR_W(14), .DATA_W(16), .MAX_WORDS(16384)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .bus       (bus),
      .core_hold (core_hold),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .words     (words)
   );

   always #5 clk = ~clk;

   // Small program memory; bit 0 of the read port can be forced low to provoke a verify error.
   always @(posedge clk) begin
      if (bus.pm_we) begin
         mem[bus.pm_addr[3:0]] <= bus.pm_din;
         wr_count = wr_count + 1;
      end
   end
   assign bus.pm_dout = stuck_bit0 ? (mem[bus.pm_addr[3:0]] & 16'hFFFE) : mem[bus.pm_addr[3:0]];

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Sends one byte after a random idle gap and returns on the negedge after it was accepted.
   task automatic apply_stimulus(input logic [7:0] b);
      logic seen;
      int   cyc;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      seen = 1'b0;
      for (cyc = 0; cyc < 50 && !seen; cyc++) begin
         #1 seen = bus.s_ready;
         @(posedge clk);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      if (!seen) check_output("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int cyc;
      for (cyc = 0; cyc < 200 && !done; cyc++) @(negedge clk);
      check_output(tag, 32'(done), 32'd1);
   endtask

   initial begin
      int cyc;
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      bus.s_data  = 8'd0;
      bus.s_valid = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] reset state");
      check_output("rst_busy",    32'(busy),        32'd0);
      check_output("rst_hold",    32'(core_hold),   32'd0);
      check_output("rst_done",    32'(done),        32'd0);
      check_output("rst_err",     32'(err),         32'd0);
      check_output("rst_words",   32'(words),       32'd0);
      check_output("rst_ready",   32'(bus.s_ready), 32'd0);
      check_output("rst_we",      32'(bus.pm_we),   32'd0);
      check_output("rst_addr",    32'(bus.pm_addr), 32'd0);
      check_output("rst_din",     32'(bus.pm_din),  32'd0);

      $display("[TB] good two-word frame");
      wr_base = wr_count;
      pulse_start();
      #1;
      check_output("t1_busy",  32'(busy),        32'd1);
      check_output("t1_hold",  32'(core_hold),   32'd1);
      check_output("t1_ready", 32'(bus.s_ready), 32'd1);
      apply_stimulus(8'h02); apply_stimulus(8'h00);
      apply_stimulus(8'hEA); apply_stimulus(8'hE0);
      apply_stimulus(8'hF0); apply_stimulus(8'hE0);
      // 02+00+EA+E0+F0+E0 = 0x39C, low byte 9C
      apply_stimulus(8'h9C);
      wait_done("t1_done");
      check_output("t1_err",    32'(err),                  32'd0);
      check_output("t1_words",  32'(words),                32'd2);
      check_output("t1_hold_f", 32'(core_hold),            32'd1);
      check_output("t1_mem0",   32'(mem[0]),               32'hE0EA);
      check_output("t1_mem1",   32'(mem[1]),               32'hE0F0);
      check_output("t1_wr",     32'(wr_count - wr_base),   32'd2);
      check_output("t1_addr",   32'(bus.pm_addr),          32'd1);
      check_output("t1_din",    32'(bus.pm_din),           32'hE0F0);
      @(negedge clk);
      check_output("t1_done_pulse", 32'(done),      32'd0);
      check_output("t1_hold_off",   32'(core_hold), 32'd0);
      check_output("t1_busy_off",   32'(busy),      32'd0);

      $display("[TB] bad checksum");
      wr_base = wr_count;
      mem[0] = 16'h0000; mem[1] = 16'h0000;
      pulse_start();
      apply_stimulus(8'h02); apply_stimulus(8'h00);
      apply_stimulus(8'hEA); apply_stimulus(8'hE0);
      apply_stimulus(8'hF0); apply_stimulus(8'hE0);
      apply_stimulus(8'h00);
      wait_done("t2_done");
      check_output("t2_err",   32'(err),                32'd1);
      check_output("t2_words", 32'(words),              32'd2);
      check_output("t2_wr",    32'(wr_count - wr_base), 32'd2);
      check_output("t2_mem1",  32'(mem[1]),             32'hE0F0);
      @(negedge clk);
      check_output("t2_hold_off", 32'(core_hold), 32'd0);

      $display("[TB] length error");
      wr_base = wr_count;
      pulse_start();
      check_output("t3_err_clr", 32'(err), 32'd0);
      apply_stimulus(8'h01); apply_stimulus(8'h40);
      check_output("t3_done_now", 32'(done), 32'd1);
      check_output("t3_err",      32'(err),  32'd2);
      check_output("t3_words",    32'(words), 32'd0);
      check_output("t3_wr",       32'(wr_count - wr_base), 32'd0);
      @(negedge clk);

      $display("[TB] empty frame with stray start");
      wr_base = wr_count;
      pulse_start();
      apply_stimulus(8'h00);
      pulse_start();
      apply_stimulus(8'h00);
      apply_stimulus(8'h00);
      wait_done("t4_done");
      check_output("t4_err",   32'(err),                32'd0);
      check_output("t4_words", 32'(words),              32'd0);
      check_output("t4_wr",    32'(wr_count - wr_base), 32'd0);
      @(negedge clk);
      check_output("t4_idle", 32'(busy), 32'd0);

      $display("[TB] abort during first write");
      wr_base = wr_count;
      pulse_start();
      apply_stimulus(8'h03); apply_stimulus(8'h00);
      apply_stimulus(8'h11); apply_stimulus(8'h22);
      for (cyc = 0; cyc < 20 && !bus.pm_we; cyc++) @(negedge clk);
      check_output("t5_we_seen", 32'(bus.pm_we), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("t5_done");
      check_output("t5_err",   32'(err),   32'd4);
      check_output("t5_words", 32'(words), 32'd1);
      repeat (5) @(negedge clk);
      check_output("t5_wr",    32'(wr_count - wr_base), 32'd1);
      check_output("t5_mem0",  32'(mem[0]),             32'h2211);

`ifdef PROG_MEM_LOADER_VERIFY_EN
      $display("[TB] verify catches stuck bit");
      wr_base = wr_count;
      stuck_bit0 = 1'b1;
      pulse_start();
      apply_stimulus(8'h01); apply_stimulus(8'h00);
      apply_stimulus(8'h01); apply_stimulus(8'h00);
      wait_done("t6_done");
      check_output("t6_err",   32'(err),                32'd3);
      check_output("t6_words", 32'(words),              32'd1);
      check_output("t6_wr",    32'(wr_count - wr_base), 32'd1);
      stuck_bit0 = 1'b0;
      @(negedge clk);
`endif

      $display("[TB] reset during load");
      pulse_start();
      apply_stimulus(8'h02);
      rst = 1'b1;
      #1;
      check_output("t7_busy",  32'(busy),        32'd0);
      check_output("t7_hold",  32'(core_hold),   32'd0);
      check_output("t7_addr",  32'(bus.pm_addr), 32'd0);
      check_output("t7_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
